// File: rtl/e_pow2k_calc_if.sv
// Request/result bus of the (1 + 2^-k)^(2^k) evaluator: start/k request, busy/done/err status, result word.
interface e_pow2k_calc_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned KW     = $clog2(WORD_W*(WORDS-1)+1)
);
  logic                    start;
  logic [KW-1:0]           k_in;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [WORDS*WORD_W-1:0] out_data;

  modport master (output start, k_in, input busy, done, err, out_data);
  modport slave  (input start, k_in, output busy, done, err, out_data);
endinterface

// File: rtl/e_pow2k_calc.sv
// Multi-precision fixed-point evaluator of (1 + 2^-k)^(2^k) using one WORD_W x WORD_W MAC.
// Optional build macro E_POW2K_ROUND_EN: round-to-nearest (ties up) on each write-back instead of truncation.
module e_pow2k_calc #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned KMAX   = WORD_W*(WORDS-1),
  parameter int unsigned KW     = $clog2(KMAX+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  e_pow2k_calc_if.slave bus
);
  localparam int unsigned DW = WORDS*WORD_W;
  localparam int unsigned FW = WORD_W*(WORDS-1);
  localparam int unsigned AW = 2*DW;
  localparam int unsigned PW = 2*WORD_W;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state, state_nx;
  logic [KW-1:0]     cnt, cnt_nx;
  logic [IW-1:0]     i_q, i_nx, j_q, j_nx;
  logic [DW-1:0]     x, x_nx;
  logic [AW-1:0]     acc, acc_nx;
  logic              busy_q, busy_nx, done_q, done_nx, err_q, err_nx;
  logic [DW-1:0]     out_q, out_nx;

  logic [WORD_W-1:0] limb [WORDS];
  logic [PW-1:0]     prod;
  logic [IW:0]       off;
  logic [AW-1:0]     prod_sh;
  logic [DW-1:0]     x_load, x_wb;

  // Limb 0 is the integer part and sits in the MSBs.
  for (genvar g = 0; g < WORDS; g++) begin : g_limb
    assign limb[g] = x[(WORDS-1-g)*WORD_W +: WORD_W];
  end

  // Product of limbs i,j lands (WORDS-1-i)+(WORDS-1-j) limbs above the accumulator LSB.
  assign prod    = PW'(limb[i_q]) * PW'(limb[j_q]);
  assign off     = (IW+1)'(2*(WORDS-1)) - (IW+1)'(i_q) - (IW+1)'(j_q);
  assign prod_sh = AW'(prod) << (32'(off) * WORD_W);

  // k = 0 places both terms on the integer LSB, giving exactly 2.
  assign x_load  = (DW'(1) << FW) + (DW'(1) << (FW - 32'(cnt)));

`ifdef E_POW2K_ROUND_EN
  assign x_wb    = DW'(acc >> FW) + DW'(acc[FW-1]);
`else
  assign x_wb    = DW'(acc >> FW);
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    i_nx     = i_q;
    j_nx     = j_q;
    x_nx     = x;
    acc_nx   = acc;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    out_nx   = out_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (32'(bus.k_in) > KMAX) begin
            err_nx = 1'b1;
          end else begin
            cnt_nx   = bus.k_in;
            busy_nx  = 1'b1;
            state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        x_nx   = x_load;
        acc_nx = '0;
        i_nx   = '0;
        j_nx   = '0;
        if (cnt == '0) begin
          out_nx   = x_load;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_DONE;
        end else begin
          state_nx = S_MUL;
        end
      end
      S_MUL: begin
        acc_nx = acc + prod_sh;
        if (j_q == IW'(WORDS-1)) begin
          j_nx = '0;
          if (i_q == IW'(WORDS-1)) begin
            i_nx     = '0;
            state_nx = S_WB;
          end else begin
            i_nx = i_q + IW'(1);
          end
        end else begin
          j_nx = j_q + IW'(1);
        end
      end
      S_WB: begin
        x_nx   = x_wb;
        acc_nx = '0;
        cnt_nx = cnt - KW'(1);
        if (cnt == KW'(1)) begin
          out_nx   = x_wb;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_DONE;
        end else begin
          state_nx = S_MUL;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      x      <= '0;
      acc    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      i_q    <= i_nx;
      j_q    <= j_nx;
      x      <= x_nx;
      acc    <= acc_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      out_q  <= out_nx;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.out_data = out_q;
endmodule

// File: tb/tb_e_pow2k_calc.sv
// Bench for e_pow2k_calc: a 2-limb and an 8-limb instance checked against a wide-integer reference.
module tb_e_pow2k_calc;
  localparam int unsigned WW  = 16;
  localparam int unsigned WA  = 2;
  localparam int unsigned WB  = 8;
  localparam int unsigned KWA = $clog2(WW*(WA-1)+1);
  localparam int unsigned KWB = $clog2(WW*(WB-1)+1);

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  e_pow2k_calc_if #(.WORD_W(WW), .WORDS(WA)) ifa ();
  e_pow2k_calc_if #(.WORD_W(WW), .WORDS(WB)) ifb ();

  e_pow2k_calc #(.WORD_W(WW), .WORDS(WA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  e_pow2k_calc #(.WORD_W(WW), .WORDS(WB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: start from 1 + 2^-k and square k times in plain wide arithmetic.
  function automatic logic [127:0] model(input int unsigned words, input int unsigned k);
    int unsigned  fw;
    logic [255:0] xv, sq;
    fw = WW*(words-1);
    xv = (256'(1) << fw) + (256'(1) << (fw - k));
    for (int unsigned n = 0; n < k; n++) begin
      sq = xv * xv;
      xv = sq >> fw;
`ifdef E_POW2K_ROUND_EN
      xv = xv + 256'(sq[fw-1]);
`endif
    end
    return 128'(xv);
  endfunction

  function automatic logic [127:0] outd(input bit s);
    return s ? ifb.out_data : 128'(ifa.out_data);
  endfunction

  // Status packed as {busy, done, err}.
  function automatic logic [2:0] st(input bit s);
    return s ? {ifb.busy, ifb.done, ifb.err} : {ifa.busy, ifa.done, ifa.err};
  endfunction

  task automatic drive(input bit s, input logic go, input int unsigned k);
    if (s) begin
      ifb.start = go;
      ifb.k_in  = KWB'(k);
    end else begin
      ifa.start = go;
      ifa.k_in  = KWA'(k);
    end
  endtask

  // One accepted computation; optional start poke while busy and during the done cycle.
  task automatic run(input bit s, input int unsigned k, input int poke, input int unsigned pk,
                     input bit poke_done);
    int unsigned  words, lat;
    int           seen;
    logic         bad;
    logic [2:0]   sv;
    logic [127:0] prev, exp;
    words = s ? WB : WA;
    lat   = 1 + k*(words*words + 1);
    exp   = model(words, k);
    prev  = outd(s);
    seen  = -1;
    bad   = 1'b0;
    @(negedge clk); drive(s, 1'b1, k);
    @(negedge clk); drive(s, 1'b0, 0);
    chk("busy_after_start", 128'(st(s)), 128'(3'b100));
    for (int n = 1; n <= int'(lat) + 2; n++) begin
      drive(s, n == poke, pk);
      @(negedge clk);
      if (!s && k == 16 && n == 6) chk("first_wb_k16", 128'(dut_a.x), 128'h1_0002);
      sv = st(s);
      if (sv[1]) begin
        seen = n;
        break;
      end
      if (sv !== 3'b100 || outd(s) !== prev) bad = 1'b1;
    end
    drive(s, 1'b0, 0);
    chk("status_while_busy", 128'(bad), 128'(0));
    chk("done_latency", 128'(seen), 128'(lat));
    chk("done_status", 128'(st(s)), 128'(3'b010));
    chk("result", outd(s), exp);
    if (poke_done) begin
      drive(s, 1'b1, 1);
      @(negedge clk); drive(s, 1'b0, 0);
      chk("start_in_done_ignored", 128'(st(s)), 128'(3'b000));
      @(negedge clk);
      chk("idle_after_done", 128'(st(s)), 128'(3'b000));
    end
  endtask

  task automatic rej(input bit s, input int unsigned k);
    logic [127:0] prev;
    prev = outd(s);
    @(negedge clk); drive(s, 1'b1, k);
    @(negedge clk); drive(s, 1'b0, 0);
    chk("err_pulse", 128'(st(s)), 128'(3'b001));
    chk("err_out_hold", outd(s), prev);
    @(negedge clk);
    chk("err_one_cycle", 128'(st(s)), 128'(3'b000));
  endtask

  initial begin
    logic [127:0] r;
    logic [15:0]  limb0;
    logic         stray;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    #1;
    chk("rst_status_a", 128'(st(1'b0)), 128'(0));
    chk("rst_out_a", outd(1'b0), 128'(0));
    chk("rst_status_b", 128'(st(1'b1)), 128'(0));
    chk("rst_out_b", outd(1'b1), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(1'b0, 0, 0, 0, 1'b0);
    chk("a_k0_const", outd(1'b0), 128'h2_0000);
    run(1'b0, 1, 0, 0, 1'b0);
    chk("a_k1_const", outd(1'b0), 128'h2_4000);
    run(1'b0, 2, 0, 0, 1'b1);
    chk("a_k2_const", outd(1'b0), 128'h2_7100);
    run(1'b0, 16, 0, 0, 1'b0);
    rej(1'b0, 17);
    rej(1'b0, 31);
    run(1'b0, 3, 4, 2, 1'b0);
    repeat (4) run(1'b0, $urandom_range(0, 16), int'($urandom_range(1, 8)), $urandom_range(0, 16), 1'b0);

    run(1'b1, 15, 0, 0, 1'b0);
    r     = outd(1'b1);
    limb0 = r[127:112];
    chk("b_k15_int_limb", 128'(limb0), 128'(2));
    rej(1'b1, $urandom_range(113, 127));

    // Asynchronous reset in the middle of a multiply pass.
    @(negedge clk); drive(1'b1, 1'b1, 20);
    @(negedge clk); drive(1'b1, 1'b0, 0);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_status", 128'(st(1'b1)), 128'(0));
    chk("midrun_rst_out", outd(1'b1), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (st(1'b1) !== 3'b000) stray = 1'b1;
    end
    chk("no_done_after_abort", 128'(stray), 128'(0));

    run(1'b1, $urandom_range(1, 24), 10, 3, 1'b1);
    repeat (2) run(1'b1, $urandom_range(0, 40), 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/e_pow2k_calc.md
Name: e_pow2k_calc

Overview:
- Parametrised fixed-point evaluator of (1 + 2^-k)^(2^k), which converges to e as k grows. Successor to the fixed-width e-calculation top.
- The limb width, limb count and run-time exponent k are all configurable. Squaring is done internally by a multi-precision engine built on a single WORD_W x WORD_W multiply-accumulate, so no separate square module is needed.
- Sits under the FPGA e-demo top. Results feed the display/UART formatter.

Parameters:
- WORD_W, 16, limb width in bits.
- WORDS, 8, number of limbs. Limb 0 is the integer part; limbs 1..WORDS-1 are the fraction.
- KMAX, WORD_W*(WORDS-1), largest accepted k. Must be <= WORD_W*(WORDS-1).
- KW, $clog2(KMAX+1), width of k_in.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only while idle.
- k_in  in  KW  exponent k, sampled together with start.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when out_data becomes valid.
- err  out  1  one-cycle pulse when start is rejected because k_in > KMAX.
- out_data  out  WORDS*WORD_W  result. Limb 0 occupies the MSBs; limb i occupies bits [(WORDS-i)*WORD_W-1 -: WORD_W].

Behaviour:
- Reset is clk-independent. During reset: busy=0, done=0, err=0, out_data=0, FSM=IDLE, accumulator and counters cleared. Reset mid-computation aborts with no done.
- Number format: X is an unsigned integer with value = X / 2^(WORD_W*(WORDS-1)).
- Squaring rule: X' = floor(X^2 / 2^(WORD_W*(WORDS-1))).
  - All WORDS^2 partial products are accumulated into a 2*WORDS-limb accumulator.
  - The accumulator is truncated back to WORDS limbs.
  - The integer part never exceeds 2, because intermediate values are < e. No overflow handling is required.
- FSM states: IDLE, LOAD, MUL, WB, DONE.
  - IDLE: start=1 and k_in<=KMAX -> latch k, busy=1, go LOAD. start=1 and k_in>KMAX -> err=1 for one cycle, stay IDLE, out_data unchanged.
  - LOAD: X = 1 + 2^-k, i.e. limb 0 = 1 and the single fraction bit at weight 2^-k set; k=0 gives X=2. Remaining count = k. If k=0 go DONE, else go MUL.
  - MUL: exactly WORDS^2 cycles, one partial product X[i]*X[j] per cycle with i outer, j inner. Each product is added into the accumulator at limb offset i+j with full carry propagation.
  - WB: X = truncated accumulator; clear accumulator; decrement count. If count=0 go DONE, else go MUL.
  - DONE: out_data = X, done=1 for one cycle, busy=0, go IDLE.
- Latency: counting the start-sampling edge as edge 0, done is high after edge 1 + k*(WORDS^2+1). busy is high from edge 0 until the edge on which done is raised.
- start while busy is ignored; no err, no queuing.
- out_data holds the last result until the next done or reset. out_data is not updated during computation.
- start coinciding with the done cycle is ignored; the FSM is not yet IDLE.

Optional Feature:
- Macro: E_POW2K_ROUND_EN.
- Defined: WB rounds to nearest, ties up. It adds accumulator bit WORD_W*(WORDS-1)-1 (the first discarded bit) to the kept value.
- Undefined: pure truncation, as specified in Behaviour.
- Latency is identical in both builds.

Test Plan:
- WORD_W=16, WORDS=2, k_in=0, start pulse -> done after edge 1, out_data=0x0002_0000; busy high for 1 cycle.
- WORDS=2, k_in=1 -> done after edge 6, out_data=0x0002_4000 (1.5^2=2.25).
- WORDS=2, k_in=2 -> done after edge 11, out_data=0x0002_7100 (1.25^4=2.44140625).
- WORDS=2, k_in=16 -> first WB yields 0x0001_0002, because 2^-32 is truncated with or without E_POW2K_ROUND_EN. Final out_data must match the bench bignum golden model bit-exactly.
- WORDS=2, k_in=17 -> err pulse for one cycle, busy stays 0, out_data unchanged. Then start during busy with a valid k -> ignored.
- WORDS=8, k_in=15 -> out_data matches the golden model, integer limb = 2; rst_n asserted mid-MUL -> all outputs 0 at once, no done, and a clean restart succeeds.
